// File: rtl/rv_instr_encoder_pkg.sv
// Shared constants for the RV32I program-loader encoder: opcodes, field kinds,
// funct3 codes, error codes and controller states.
package rv_enc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        K_R      = 3'd0,
        K_IALU   = 3'd1,
        K_LW     = 3'd2,
        K_SW     = 3'd3,
        K_BRANCH = 3'd4,
        K_JAL    = 3'd5,
        K_JALR   = 3'd6,
        K_LUI    = 3'd7
    } kind_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_IMM   = 2'd1;
    localparam logic [1:0] ERR_F3    = 2'd2;
    localparam logic [1:0] ERR_SHAMT = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

endpackage

// File: rtl/rv_instr_encoder_if.sv
// Field-bundle input stream, memory write port and status outputs of the encoder.
interface rv_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              stop;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we;
    logic              mem_ready;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   instr_count;
    logic              err;
    logic [1:0]        err_code;
    logic              full;

    modport master (
        output start, stop, in_valid, in_kind, in_funct3, in_funct7b5,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, instr_count,
               err, err_code, full
    );

    modport slave (
        input  start, stop, in_valid, in_kind, in_funct3, in_funct7b5,
               in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, instr_count,
               err, err_code, full
    );
endinterface

// File: rtl/rv_imm_pack.sv
// Combinational packer: field bundle -> RV32I word plus legality verdict and
// the error code explaining a rejection.
module rv_imm_pack
    import rv_enc_pkg::*;
(
    input  kind_e              i_kind,
    input  logic [2:0]         i_funct3,
    input  logic               i_funct7b5,
    input  logic [4:0]         i_rd,
    input  logic [4:0]         i_rs1,
    input  logic [4:0]         i_rs2,
    input  logic signed [31:0] i_imm,
    output logic [31:0]        o_word,
    output logic               o_legal,
    output logic [1:0]         o_code
);

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic branch_f3_ok(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
    endfunction

    logic [6:0] w_f7;
    logic       w_imm12_ok;

    assign w_f7       = i_funct7b5 ? 7'b0100000 : 7'b0000000;
    assign w_imm12_ok = in_range(i_imm, -32'sd2048, 32'sd2047);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        o_code  = ERR_NONE;
        case (i_kind)
            K_R: begin
                o_word = {w_f7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
            end
            K_IALU: begin
                // Shifts carry shamt in imm[4:0]; the upper immediate bits hold funct7.
                if ((i_funct3 == F3_SLL) || (i_funct3 == F3_SR)) begin
                    o_word = {w_f7, i_imm[4:0], i_rs1, i_funct3, i_rd, OP_I};
                    if (i_imm[31:5] != 27'd0) begin
                        o_legal = 1'b0;
                        o_code  = ERR_SHAMT;
                    end
                end else begin
                    o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_I};
                    if (!w_imm12_ok) begin
                        o_legal = 1'b0;
                        o_code  = ERR_IMM;
                    end
                end
            end
            K_LW: begin
                o_word = {i_imm[11:0], i_rs1, F3_WORD, i_rd, OP_LOAD};
                if (!w_imm12_ok) begin
                    o_legal = 1'b0;
                    o_code  = ERR_IMM;
                end
            end
            K_SW: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, F3_WORD, i_imm[4:0], OP_STORE};
                if (!w_imm12_ok) begin
                    o_legal = 1'b0;
                    o_code  = ERR_IMM;
                end
            end
            K_BRANCH: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], OP_BRANCH};
                if (!in_range(i_imm, -32'sd4096, 32'sd4094) || i_imm[0]) begin
                    o_legal = 1'b0;
                    o_code  = ERR_IMM;
                end else if (!branch_f3_ok(i_funct3)) begin
                    o_legal = 1'b0;
                    o_code  = ERR_F3;
                end
            end
            K_JAL: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OP_JAL};
                if (!in_range(i_imm, -32'sd1048576, 32'sd1048574) || i_imm[0]) begin
                    o_legal = 1'b0;
                    o_code  = ERR_IMM;
                end
            end
            K_JALR: begin
                o_word = {i_imm[11:0], i_rs1, F3_JALR, i_rd, OP_JALR};
                if (!w_imm12_ok) begin
                    o_legal = 1'b0;
                    o_code  = ERR_IMM;
                end
            end
            K_LUI: begin
                o_word = {i_imm[31:12], i_rd, OP_LUI};
                if (i_imm[11:0] != 12'd0) begin
                    o_legal = 1'b0;
                    o_code  = ERR_IMM;
                end
            end
            default: begin
                o_word = '0;
            end
        endcase
    end

endmodule

// File: rtl/rv_instr_encoder.sv
// Program loader: accepts field bundles, encodes them and writes the words to
// instruction memory at consecutive addresses through a one-deep output register.
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input logic             clk,
    input logic             rst_n,
    rv_instr_encoder_if.slave bus
);

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]         r_state;
    logic               r_vld_p1;
    logic [31:0]        r_addr_p1;
    logic [31:0]        r_wdata_p1;
    logic [31:0]        r_wptr;
    logic [ADDR_W:0]    r_count;
    logic               r_full;
    logic               r_err;
    logic [1:0]         r_err_code;

    logic [31:0]        w_word;
    logic               w_legal;
    logic [1:0]         w_code;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load;
    logic [ADDR_W:0]    w_count_nxt;

    rv_imm_pack u_pack (
        .i_kind     (kind_e'(bus.in_kind)),
        .i_funct3   (bus.in_funct3),
        .i_funct7b5 (bus.in_funct7b5),
        .i_rd       (bus.in_rd),
        .i_rs1      (bus.in_rs1),
        .i_rs2      (bus.in_rs2),
        .i_imm      (bus.in_imm),
        .o_word     (w_word),
        .o_legal    (w_legal),
        .o_code     (w_code)
    );

    assign w_in_ready  = (r_state == ST_RUN) && !r_full && (!r_vld_p1 || bus.mem_ready);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_load      = w_accept && w_legal;
    assign w_count_nxt = r_count + 1'b1;

    // Stage p0 -> p1: encoded word captured into the memory write register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_vld_p1   <= 1'b0;
            r_addr_p1  <= BASE_ADDR;
            r_wdata_p1 <= 32'd0;
            r_wptr     <= BASE_ADDR;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (bus.start) begin
            // start outranks stop and any handshake, and discards a pending write
            r_state    <= ST_RUN;
            r_vld_p1   <= 1'b0;
            r_addr_p1  <= BASE_ADDR;
            r_wptr     <= BASE_ADDR;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_load) begin
                r_vld_p1   <= 1'b1;
                r_addr_p1  <= r_wptr;
                r_wdata_p1 <= w_word;
                r_wptr     <= r_wptr + 32'd4;
                r_count    <= w_count_nxt;
                if (w_count_nxt == CNT_MAX) begin
                    r_full <= 1'b1;
                end
            end else if (r_vld_p1 && bus.mem_ready) begin
                r_vld_p1 <= 1'b0;
            end

            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_code <= w_code;
                end
            end

            case (r_state)
                ST_RUN: begin
                    if (bus.stop) begin
                        r_state <= ST_DRAIN;
                    end else if (w_load && (w_count_nxt == CNT_MAX)) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.stop) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!r_vld_p1 || bus.mem_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.mem_we      = r_vld_p1;
    assign bus.mem_addr    = r_addr_p1;
    assign bus.mem_wdata   = r_wdata_p1;
    assign bus.instr_count = r_count;
    assign bus.err         = r_err;
    assign bus.err_code    = r_err_code;
    assign bus.full        = r_full;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Scoreboard bench for rv_instr_encoder: a full-size instance for encoding and
// handshake scenarios, and an ADDR_W=2 instance for the full/stop/restart path.
module tb_rv_instr_encoder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rv_instr_encoder_if #(.ADDR_W(10)) b ();
    rv_instr_encoder_if #(.ADDR_W(2))  s ();

    rv_instr_encoder #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    rv_instr_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s.slave)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp2_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_addr;
    int          m_count;

    // Each completed write (mem_we & mem_ready at the coming edge) pops one expectation
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && !b.start && b.mem_we && b.mem_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got addr=%h data=%h expected no write", b.mem_addr, b.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({b.mem_addr, b.mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             b.mem_addr, b.mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (rst_n && !s.start && s.mem_we && s.mem_ready) begin
            checks++;
            if (exp2_q.size() == 0) begin
                errors++;
                $display("FAIL small_write_unexpected got addr=%h data=%h expected no write", s.mem_addr, s.mem_wdata);
            end else begin
                e = exp2_q.pop_front();
                if ({s.mem_addr, s.mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL small_write got addr=%h data=%h expected addr=%h data=%h",
                             s.mem_addr, s.mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        m_addr  = 32'h0;
        m_count = 0;
    endtask

    task automatic send(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic legal, input logic [31:0] word);
        int n;
        b.in_kind = k; b.in_funct3 = f3; b.in_funct7b5 = f7;
        b.in_rd = rd; b.in_rs1 = rs1; b.in_rs2 = rs2; b.in_imm = imm;
        b.in_valid = 1'b1;
        if (legal) begin
            exp_q.push_back({m_addr, word});
            m_addr  += 32'd4;
            m_count += 1;
        end
        n = 0;
        @(negedge clk);
        while (!b.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout got in_ready=0 for %0d cycles expected 1", n);
        end
        tick();
        b.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b expected 0", b.mem_we); end
        checks++; if (b.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h expected 0", b.mem_addr); end
        checks++; if (b.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h expected 0", b.mem_wdata); end
        checks++; if (b.instr_count !== 11'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", b.instr_count); end
        checks++; if ({b.err, b.err_code, b.full} !== 4'b0) begin errors++; $display("FAIL reset_status got %b expected 0000", {b.err, b.err_code, b.full}); end
        checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b expected 0", b.in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_r_add();
        b.mem_ready = 1'b1;
        do_start();
        send(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        checks++; if (b.mem_we !== 1'b1) begin errors++; $display("FAIL radd_mem_we got %b expected 1", b.mem_we); end
        checks++; if (b.mem_addr !== 32'h0) begin errors++; $display("FAIL radd_addr got %h expected 0", b.mem_addr); end
        checks++; if (b.mem_wdata !== 32'h002081B3) begin errors++; $display("FAIL radd_wdata got %h expected 002081b3", b.mem_wdata); end
        checks++; if (b.instr_count !== 11'd1) begin errors++; $display("FAIL radd_count got %0d expected 1", b.instr_count); end
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        b.mem_ready = 1'b1;
        do_start();
        send(3'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00293);
        send(3'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423);
        checks++; if (b.instr_count !== 11'(m_count)) begin errors++; $display("FAIL b2b_count got %0d expected %0d", b.instr_count, m_count); end
        checks++; if (b.mem_addr !== 32'h4) begin errors++; $display("FAIL b2b_addr got %h expected 4", b.mem_addr); end
        tick(); tick();
    endtask

    task automatic test_encodings();
        b.mem_ready = 1'b1;
        do_start();
        send(3'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE208EE3);
        send(3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 32'h001000EF);
        send(3'd7, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h12345237);
        send(3'd1, 3'b101, 1'b1, 5'd6, 5'd7, 5'd0, 32'd3, 1'b1, 32'h4033D313);
        checks++; if (b.instr_count !== 11'(m_count)) begin errors++; $display("FAIL enc_count got %0d expected %0d", b.instr_count, m_count); end
        tick(); tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL enc_drain got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_illegal();
        b.mem_ready = 1'b1;
        do_start();
        send(3'd1, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
        send(3'd4, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0);
        checks++; if (b.err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b expected 1", b.err); end
        checks++; if (b.err_code !== 2'd1) begin errors++; $display("FAIL illegal_err_code got %0d expected 1", b.err_code); end
        checks++; if (b.instr_count !== 11'd0) begin errors++; $display("FAIL illegal_count got %0d expected 0", b.instr_count); end
        checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL illegal_mem_we got %b expected 0", b.mem_we); end
        send(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        checks++; if (b.mem_addr !== 32'h0 || b.instr_count !== 11'd1) begin errors++; $display("FAIL illegal_resume got addr=%h count=%0d expected addr=0 count=1", b.mem_addr, b.instr_count); end
        send(3'd1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0, 32'h0);
        checks++; if (b.err_code !== 2'd1 || b.instr_count !== 11'd1) begin errors++; $display("FAIL illegal_sticky got code=%0d count=%0d expected code=1 count=1", b.err_code, b.instr_count); end
        tick();
        do_start();
        checks++; if (b.err !== 1'b0 || b.err_code !== 2'd0) begin errors++; $display("FAIL start_clears_err got err=%b code=%0d expected 0 0", b.err, b.err_code); end
        send(3'd1, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0, 32'h0);
        checks++; if (b.err_code !== 2'd3) begin errors++; $display("FAIL shamt_code got %0d expected 3", b.err_code); end
        tick();
    endtask

    task automatic test_stall();
        b.mem_ready = 1'b0;
        do_start();
        send(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        b.in_kind = 3'd0; b.in_funct3 = 3'b000; b.in_funct7b5 = 1'b1;
        b.in_rd = 5'd9; b.in_rs1 = 5'd10; b.in_rs2 = 5'd11; b.in_imm = 32'd0;
        b.in_valid = 1'b1;
        exp_q.push_back({m_addr, 32'h40B504B3});
        m_addr += 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (b.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle %0d got %b expected 0", i, b.in_ready); end
            checks++; if (b.mem_addr !== 32'h0 || b.mem_wdata !== 32'h002081B3 || b.mem_we !== 1'b1) begin
                errors++; $display("FAIL stall_hold got we=%b addr=%h data=%h expected we=1 addr=0 data=002081b3", b.mem_we, b.mem_addr, b.mem_wdata);
            end
            tick();
        end
        b.mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b expected 1", b.in_ready); end
        tick();
        b.in_valid = 1'b0;
        checks++; if (b.mem_addr !== 32'h4 || b.mem_wdata !== 32'h40B504B3) begin errors++; $display("FAIL release_next got addr=%h data=%h expected addr=4 data=40b504b3", b.mem_addr, b.mem_wdata); end
        tick();
        checks++; if (b.mem_we !== 1'b0) begin errors++; $display("FAIL release_we_drop got %b expected 0", b.mem_we); end
    endtask

    task automatic test_stop_drain();
        b.mem_ready = 1'b0;
        do_start();
        send(3'd0, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
        b.stop = 1'b1;
        tick();
        b.stop = 1'b0;
        tick();
        checks++; if (b.mem_we !== 1'b1 || b.in_ready !== 1'b0) begin errors++; $display("FAIL drain_hold got we=%b in_ready=%b expected we=1 in_ready=0", b.mem_we, b.in_ready); end
        b.mem_ready = 1'b1;
        tick();
        b.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (b.mem_we !== 1'b0 || b.in_ready !== 1'b0) begin errors++; $display("FAIL idle_after_drain got we=%b in_ready=%b expected 0 0", b.mem_we, b.in_ready); end
        tick();
        b.in_valid = 1'b0;
        do_start();
        @(negedge clk);
        checks++; if (b.in_ready !== 1'b1) begin errors++; $display("FAIL restart_in_ready got %b expected 1", b.in_ready); end
        tick();
    endtask

    task automatic test_full();
        s.mem_ready = 1'b1;
        s.start = 1'b1;
        tick();
        s.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s.in_kind = 3'd0; s.in_funct3 = 3'b000; s.in_funct7b5 = 1'b0;
            s.in_rd = 5'(i + 1); s.in_rs1 = 5'd1; s.in_rs2 = 5'd2; s.in_imm = 32'd0;
            s.in_valid = 1'b1;
            exp2_q.push_back({32'(i * 4), r_add(5'(i + 1), 5'd1, 5'd2)});
            @(negedge clk);
            checks++; if (s.in_ready !== 1'b1) begin errors++; $display("FAIL full_accept %0d got in_ready=%b expected 1", i, s.in_ready); end
            tick();
        end
        s.in_rd = 5'd5;
        @(negedge clk);
        checks++; if (s.in_ready !== 1'b0) begin errors++; $display("FAIL full_block got in_ready=%b expected 0", s.in_ready); end
        checks++; if (s.full !== 1'b1 || s.instr_count !== 3'd4) begin errors++; $display("FAIL full_flag got full=%b count=%0d expected 1 4", s.full, s.instr_count); end
        tick(); tick();
        checks++; if (s.instr_count !== 3'd4 || s.mem_addr !== 32'hC) begin errors++; $display("FAIL full_stable got count=%0d addr=%h expected 4 c", s.instr_count, s.mem_addr); end
        s.in_valid = 1'b0;
        s.stop = 1'b1;
        tick();
        s.stop = 1'b0;
        tick(); tick();
        checks++; if (exp2_q.size() != 0) begin errors++; $display("FAIL full_writes got %0d pending expected 0", exp2_q.size()); end
        s.start = 1'b1;
        tick();
        s.start = 1'b0;
        @(negedge clk);
        checks++; if (s.instr_count !== 3'd0 || s.mem_addr !== 32'h0 || s.full !== 1'b0) begin
            errors++; $display("FAIL full_restart got count=%0d addr=%h full=%b expected 0 0 0", s.instr_count, s.mem_addr, s.full);
        end
        checks++; if (s.in_ready !== 1'b1) begin errors++; $display("FAIL full_restart_ready got %b expected 1", s.in_ready); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        b.start = 1'b0; b.stop = 1'b0; b.in_valid = 1'b0; b.mem_ready = 1'b0;
        b.in_kind = '0; b.in_funct3 = '0; b.in_funct7b5 = 1'b0;
        b.in_rd = '0; b.in_rs1 = '0; b.in_rs2 = '0; b.in_imm = '0;
        s.start = 1'b0; s.stop = 1'b0; s.in_valid = 1'b0; s.mem_ready = 1'b0;
        s.in_kind = '0; s.in_funct3 = '0; s.in_funct7b5 = 1'b0;
        s.in_rd = '0; s.in_rs1 = '0; s.in_rs2 = '0; s.in_imm = '0;
        m_addr = 32'h0;
        m_count = 0;
        test_reset();
        test_r_add();
        test_back_to_back();
        test_encodings();
        test_illegal();
        test_stall();
        test_stop_drain();
        test_full();
        tick(); tick();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain got %0d pending expected 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
